// File: rtl/dac_sample_streamer.sv
// Paced replay of 8-bit sample codes to the DAC_8BIT d0..d7 pins.
// Samples arrive over a valid/ready write port into a small FIFO.
module dac_sample_streamer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DIV_W      = 16,
    parameter logic [7:0]  RESET_CODE = 8'h80
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DIV_W-1:0]         div,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    output logic [7:0]               dac_d,
    output logic                     sample_strobe,
    output logic                     underflow,
    input  logic                     uf_clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [DIV_W-1:0] cnt;

    logic             tick_c;
    logic             push_c;
    logic             pop_c;
    logic [LW-1:0]    level_nxt_c;

    // Tick uses >= so a shrinking divider takes effect without a wrap-around stall.
    always_comb begin
        tick_c      = en && (cnt >= div);
        push_c      = wr_valid && !full;
        pop_c       = tick_c && !empty;
        level_nxt_c = level;
        unique case ({push_c, pop_c})
            2'b10:   level_nxt_c = level + LW'(1);
            2'b01:   level_nxt_c = level - LW'(1);
            default: level_nxt_c = level;
        endcase
    end

    assign wr_ready = !full;

    // Storage carries no reset; pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt_c;
            empty <= (level_nxt_c == '0);
            full  <= (level_nxt_c == LW'(DEPTH));
        end
    end

    // Sample-rate pacing counter, held at zero while playback is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_d         <= RESET_CODE;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= pop_c;
            if (pop_c) begin
                dac_d <= mem[rd_ptr];
            end
        end
    end

    // A starved tick wins over a coincident clear so no underflow event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (tick_c && empty) begin
            underflow <= 1'b1;
        end else if (uf_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_sample_streamer.sv
// Bench for dac_sample_streamer: queue-based reference model, scoreboard of
// expected DAC codes, directed scenarios followed by randomized traffic.
module tb_dac_sample_streamer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic             wr_valid;
    logic [7:0]       wr_data;
    logic             wr_ready;
    logic [7:0]       dac_d;
    logic             sample_strobe;
    logic             underflow;
    logic             uf_clr;
    logic [LW-1:0]    level;
    logic             empty;
    logic             full;

    dac_sample_streamer #(
        .DEPTH(DEPTH),
        .DIV_W(DIV_W),
        .RESET_CODE(8'h80)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .div(div),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .dac_d(dac_d),
        .sample_strobe(sample_strobe),
        .underflow(underflow),
        .uf_clr(uf_clr),
        .level(level),
        .empty(empty),
        .full(full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_dac = 8'h80;
    logic       m_strobe = 1'b0;
    logic       m_uf = 1'b0;
    int         m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: period div+1 while enabled; ticks drain the queue or flag starvation.
    always @(posedge clk) begin
        bit tick;
        bit do_push;
        bit do_pop;
        if (rst) begin
            mq.delete();
            m_dac    = 8'h80;
            m_strobe = 1'b0;
            m_uf     = 1'b0;
            m_cnt    = 0;
        end else begin
            tick    = en && (m_cnt >= int'(div));
            do_push = wr_valid && (mq.size() < DEPTH);
            do_pop  = tick && (mq.size() != 0);
            m_strobe = do_pop;
            if (do_pop) begin
                m_dac = mq.pop_front();
                exp_q.push_back(m_dac);
            end
            if (tick && !do_pop) m_uf = 1'b1;
            else if (uf_clr)     m_uf = 1'b0;
            if (do_push) mq.push_back(wr_data);
            m_cnt = (!en || tick) ? 0 : m_cnt + 1;
        end
    end

    // Monitor: every cycle compare status, and on each strobe pop the scoreboard.
    always @(negedge clk) begin
        if (mon_on) begin
            check("dac_d", 32'(dac_d), 32'(m_dac));
            check("sample_strobe", 32'(sample_strobe), 32'(m_strobe));
            check("underflow", 32'(underflow), 32'(m_uf));
            check("level", 32'(level), 32'(mq.size()));
            check("empty", 32'(empty), 32'(mq.size() == 0));
            check("full", 32'(full), 32'(mq.size() == DEPTH));
            check("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
            if (sample_strobe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sample_order: strobe with dac_d %0h but no sample expected at %0t",
                             dac_d, $time);
                end else begin
                    check("sample_order", 32'(dac_d), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        int guard = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (wr_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: wr_ready stuck at %b, required 1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic uf_pulse();
        uf_clr = 1'b1;
        cyc(1);
        uf_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        rst = 1'b1; en = 1'b0; div = '0; wr_valid = 1'b0; wr_data = '0; uf_clr = 1'b0;
        cyc(2);
        check("rst_dac_d", 32'(dac_d), 32'h80);
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);
        rst = 1'b0;
        mon_on = 1'b1;

        // Paced playback at div=3
        div = 16'd3; en = 1'b1;
        push(8'h10); push(8'h20); push(8'h30);
        cyc(20);
        check("paced_underflow_after_drain", 32'(underflow), 32'd1);
        check("paced_last_code", 32'(dac_d), 32'h30);
        en = 1'b0;
        uf_pulse();
        check("uf_clr_alone", 32'(underflow), 32'd0);

        // Back-pressure with a wrapped write pointer
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
        check("bp_full", 32'(full), 32'd1);
        check("bp_level", 32'(level), 32'd8);
        wr_valid = 1'b1; wr_data = 8'hA8;
        cyc(3);
        check("bp_wr_ready_low", 32'(wr_ready), 32'd0);
        div = '0; en = 1'b1;
        cyc(1);
        check("bp_first_pop", 32'(dac_d), 32'hA0);
        check("bp_ready_after_pop", 32'(wr_ready), 32'd1);
        guard = 0;
        while (wr_ready !== 1'b1 && guard < 50) begin cyc(1); guard++; end
        cyc(1);
        wr_valid = 1'b0;
        cyc(12);
        check("bp_last_code", 32'(dac_d), 32'hA8);

        // Underflow and clear/set priority
        en = 1'b0;
        uf_pulse();
        div = 16'd1; en = 1'b1;
        cyc(2);
        check("uf_rise", 32'(underflow), 32'd1);
        check("uf_dac_held", 32'(dac_d), 32'hA8);
        check("uf_no_strobe", 32'(sample_strobe), 32'd0);
        uf_clr = 1'b1;
        cyc(1);
        check("uf_clr_off_tick", 32'(underflow), 32'd0);
        cyc(1);
        check("uf_set_beats_clr", 32'(underflow), 32'd1);
        uf_clr = 1'b0;

        // Simultaneous push and pop at level 4
        en = 1'b0;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        div = '0; en = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_data = 8'($urandom);
            cyc(1);
        end
        check("simul_level_4", 32'(level), 32'd4);
        wr_valid = 1'b0;
        cyc(8);

        // Push on a tick that finds the FIFO empty
        en = 1'b0;
        uf_pulse();
        div = 16'd2; en = 1'b1;
        cyc(2);
        wr_valid = 1'b1; wr_data = 8'h5A;
        cyc(1);
        wr_valid = 1'b0;
        check("tick_push_uf", 32'(underflow), 32'd1);
        check("tick_push_level", 32'(level), 32'd1);
        cyc(3);
        check("tick_push_out", 32'(dac_d), 32'h5A);
        check("tick_push_strobe", 32'(sample_strobe), 32'd1);

        // Divider shrinks mid-count
        en = 1'b0;
        for (int i = 0; i < 6; i++) push(8'($urandom));
        div = 16'd100; en = 1'b1;
        cyc(50);
        div = 16'd2;
        cyc(1);
        check("div_shrink_tick", 32'(sample_strobe), 32'd1);
        cyc(2);
        check("div_shrink_gap", 32'(sample_strobe), 32'd0);
        cyc(1);
        check("div_shrink_period", 32'(sample_strobe), 32'd1);

        // Reset with buffered samples
        en = 1'b0;
        push(8'($urandom));
        check("pre_rst_level", 32'(level), 32'd5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_dac", 32'(dac_d), 32'h80);
        check("mid_rst_empty", 32'(empty), 32'd1);

        // Randomized traffic in phases of differing write pressure
        for (int ph = 0; ph < 6; ph++) begin
            int wr_pct;
            wr_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 95);
            for (int i = 0; i < 500; i++) begin
                en       = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 19) == 0) div = DIV_W'($urandom_range(0, 4));
                wr_valid = ($urandom_range(0, 99) < wr_pct);
                wr_data  = 8'($urandom);
                uf_clr   = ($urandom_range(0, 7) == 0);
                rst      = ($urandom_range(0, 299) == 0);
                cyc(1);
            end
        end
        rst = 1'b0; en = 1'b0; wr_valid = 1'b0; uf_clr = 1'b0;
        cyc(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_sample_streamer.md
Name: dac_sample_streamer

Overview:
- Transmit-side counterpart to the SAR capture path: accepts 8-bit sample codes over a valid/ready write port and buffers them in a small FIFO.
- Replays the codes to the DAC_8BIT data inputs (d0..d7) at a programmable sample rate.
- Sits in the digital user area next to the SAR controller; its dac_d bus drives the DAC d0..d7 pins.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- DIV_W, 16, width of the sample-rate divider.
- RESET_CODE, 8'h80, DAC code driven after reset (mid-scale).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  playback enable; 0 = pacing counter and pops frozen.
- div  input  DIV_W  sample period minus one, in clk cycles (0 = every cycle).
- wr_valid  input  1  write request.
- wr_data  input  8  sample code.
- wr_ready  output  1  FIFO can accept; equals !full, combinational from occupancy.
- dac_d  output  8  registered code to DAC; bit i drives d<i>.
- sample_strobe  output  1  one-cycle pulse in the first cycle a new dac_d is valid.
- underflow  output  1  sticky: a sample tick found the FIFO empty.
- uf_clr  input  1  clears underflow.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- empty  output  1  level==0.
- full  output  1  level==DEPTH.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - dac_d=RESET_CODE; sample_strobe=0; underflow=0.
  - FIFO pointers and level=0; empty=1; full=0; wr_ready=1; pacing counter=0.
  - Reset mid-playback discards all buffered samples. The DAC code returns to RESET_CODE on the next edge.
- Write:
  - A push occurs when wr_valid && wr_ready at the edge; wr_data is stored at the write pointer.
  - The pointer wraps modulo DEPTH.
  - When full, wr_ready=0, so no push occurs even if a pop happens in the same cycle.
- Pacing:
  - While en=1, cnt increments each cycle.
  - tick = en && (cnt >= div); on tick, cnt returns to 0. The period is div+1 cycles.
  - The >= compare makes a smaller div written mid-count take effect immediately with no stall.
  - While en=0, cnt=0 and tick=0. After en rises, the first tick is div+1 cycles later (cycle div relative to the en rise).
- Pop:
  - A pop occurs when tick && !empty, with empty evaluated from the pre-edge level.
  - At that edge, dac_d <= FIFO[rd_ptr]; rd_ptr advances with wrap; sample_strobe<=1 for the following cycle only.
  - Latency: a sample pushed into an empty FIFO is on dac_d no earlier than the edge of the next tick after the push edge.
- Underflow:
  - tick && empty sets underflow; dac_d holds its last value and sample_strobe stays 0.
  - Set has priority over a simultaneous uf_clr.
  - uf_clr alone clears it at the next edge.
- Simultaneous push and pop (not full, not empty): level unchanged, both pointers advance.
- Push into an empty FIFO in the same cycle as a tick: the tick sees empty, so underflow is set and the data is stored. That sample is output at the next tick.
- level, empty and full are updated at every edge from push/pop. They never exceed DEPTH and never go below 0.

Test Plan:
- Reset: hold rst 2 cycles -> dac_d=8'h80, level=0, empty=1, wr_ready=1, underflow=0, sample_strobe=0.
- Paced playback:
  - Stimulus: div=3, en=1, push 8'h10, 8'h20, 8'h30.
  - Required: dac_d steps 10->20->30 exactly 4 cycles apart, one sample_strobe per step, level decrements 3->0, underflow=0 until the next tick.
- Full/back-pressure:
  - Stimulus: en=0, push 9 samples with wr_valid held.
  - Required: first 8 accepted, full=1, wr_ready=0, 9th held.
  - Then: en=1, div=0 -> the 9th is accepted in the cycle after the first pop. Output order equals write order, including across pointer wrap.
- Underflow:
  - Stimulus: div=1, en=1, FIFO empty.
  - Required: underflow rises after 2 cycles, dac_d unchanged, no strobe.
  - Then: uf_clr pulse -> underflow=0. uf_clr coincident with a tick on empty -> underflow stays 1.
- Simultaneous and edge events:
  - Push on the same cycle as a pop with level=4 -> level stays 4.
  - Push on a tick cycle with the FIFO empty -> underflow=1, value output at the following tick.
- Mid-operation changes:
  - Change div from 100 to 2 with cnt=50 -> tick on the next cycle, then every 3 cycles.
  - Assert rst mid-stream with level=5 -> level=0, dac_d=8'h80 on the next edge.
